// File: rtl/pwm_fade_array.sv
// Multi-channel PWM LED driver: one shared period counter, per-channel duty
// with off/static/breathe/blink modes and period-boundary shadow loading.

module pwm_fade_lane #(
   parameter int CNT_W    = 16,
   parameter int INIT     = 1,
   parameter int DUTY_MIN = 1,
   parameter int DUTY_MAX = 14000,
   parameter int STEP     = 1,
   parameter bit ODD      = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             out_en_i,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic             load_i,
   input  logic             reload_i,
   input  logic             stat_ld_i,
   input  logic [CNT_W-1:0] stat_val_i,
   input  logic             blink_ld_i,
   input  logic             phase_i,
   input  logic             brth_ld_i,
   output logic             led_o
);
   localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT);
   localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(DUTY_MIN);
   localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(DUTY_MAX);
   localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);
   localparam logic [CNT_W:0]   MIN_X  = (CNT_W+1)'(DUTY_MIN);
   localparam logic [CNT_W:0]   MAX_X  = (CNT_W+1)'(DUTY_MAX);
   localparam logic [CNT_W:0]   STEP_X = (CNT_W+1)'(STEP);

   logic [CNT_W-1:0] duty_q, duty_d, active_q;
   logic             dn_q, dn_d;
   logic             led_q;
   logic [CNT_W:0]   duty_x;

   assign duty_x = {1'b0, duty_q};

   // One extra bit on the ramp compares keeps the clamps free of wrap-around.
   always_comb begin
      duty_d = duty_q;
      dn_d   = dn_q;
      if (reload_i) begin
         duty_d = INIT_C;
         dn_d   = 1'b0;
      end else if (stat_ld_i) begin
         duty_d = stat_val_i;
      end else if (blink_ld_i) begin
         duty_d = (phase_i ^ ODD) ? MIN_C : MAX_C;
      end else if (brth_ld_i) begin
         if (!dn_q) begin
            if (duty_x + STEP_X >= MAX_X) begin
               duty_d = MAX_C;
               dn_d   = 1'b1;
            end else begin
               duty_d = duty_q + STEP_C;
            end
         end else begin
            if (duty_x <= MIN_X + STEP_X) begin
               duty_d = MIN_C;
               dn_d   = 1'b0;
            end else begin
               duty_d = duty_q - STEP_C;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_q   <= INIT_C;
         active_q <= INIT_C;
         dn_q     <= 1'b0;
         led_q    <= 1'b0;
      end else begin
         duty_q <= duty_d;
         dn_q   <= dn_d;
         if (load_i) active_q <= duty_q;
         led_q <= out_en_i && (cnt_i < active_q);
      end
   end

   assign led_o = led_q;
endmodule

module pwm_fade_array #(
   parameter int N_CH       = 8,
   parameter int CNT_W      = 16,
   parameter int CLK_FREQ   = 25_000_000,
   parameter int PWM_FREQ   = 1_250,
   parameter int STEP_TICKS = 3_125_000,
   parameter int DUTY_MIN   = 1,
   parameter int DUTY_MAX   = (CLK_FREQ / PWM_FREQ) * 7 / 10,
   parameter int STEP       = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] static_duty,
   output logic [N_CH-1:0]  leds,
   output logic             pwm_sync
);
   localparam int               PERIOD    = CLK_FREQ / PWM_FREQ;
   localparam int               TICK_W    = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
   localparam logic [CNT_W-1:0] PER_C     = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);
   localparam int               STAGGER   = (DUTY_MAX - DUTY_MIN) / N_CH;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [1:0]        mode_q, mode_d;
   logic              phase_q, phase_d;
   logic              sync_q;
   logic              tick, load, entry, out_en;
   logic [CNT_W-1:0]  stat_val;
   logic [N_CH-1:0]   led_w;

   assign tick     = enable && (tick_q == TICK_LAST);
   assign load     = enable && (cnt_q == PER_LAST);
   assign entry    = enable && (mode == 2'd2) && (mode_q != 2'd2);
   assign out_en   = enable && (mode != 2'd0);
   assign stat_val = (static_duty > PER_C) ? PER_C : static_duty;

   always_comb begin
      cnt_d   = cnt_q;
      tick_d  = tick_q;
      mode_d  = mode_q;
      phase_d = phase_q;
      if (enable) begin
         cnt_d  = (cnt_q == PER_LAST) ? '0 : cnt_q + 1'b1;
         tick_d = tick ? '0 : tick_q + 1'b1;
         mode_d = mode;
         if (tick && mode == 2'd3) phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         tick_q  <= '0;
         mode_q  <= 2'd0;
         phase_q <= 1'b0;
         sync_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         mode_q  <= mode_d;
         phase_q <= phase_d;
         sync_q  <= enable && (cnt_q == '0);
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_lane
      pwm_fade_lane #(
         .CNT_W    (CNT_W),
         .INIT     (DUTY_MIN + g * STAGGER),
         .DUTY_MIN (DUTY_MIN),
         .DUTY_MAX (DUTY_MAX),
         .STEP     (STEP),
         .ODD      ((g % 2) == 1)
      ) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .out_en_i   (out_en),
         .cnt_i      (cnt_q),
         .load_i     (load),
         .reload_i   (entry),
         .stat_ld_i  (enable && mode == 2'd1),
         .stat_val_i (stat_val),
         .blink_ld_i (tick && mode == 2'd3),
         .phase_i    (phase_d),
         .brth_ld_i  (tick && mode == 2'd2),
         .led_o      (led_w[g])
      );
   end

   assign leds     = led_w;
   assign pwm_sync = sync_q;
endmodule

// File: tb/tb_pwm_fade_array.sv
// Randomized and directed bench for pwm_fade_array against a per-cycle
// behavioural model written with plain integer arithmetic.

module tb_pwm_fade_array;
   localparam int N    = 4;
   localparam int CW   = 16;
   localparam int CF   = 1000;
   localparam int PF   = 100;
   localparam int PER  = CF / PF;
   localparam int ST   = 20;
   localparam int DMIN = 1;
   localparam int DMAX = 8;
   localparam int STP  = 2;

   logic          clk = 1'b0;
   logic          rst_n, enable;
   logic [1:0]    mode;
   logic [CW-1:0] static_duty;
   logic [N-1:0]  leds;
   logic          pwm_sync;

   int n_chk = 0, n_fail = 0;
   int m_cnt, m_tick, m_phase, m_pmode, m_sync, m_leds;
   int m_duty[N], m_act[N], m_dir[N];
   int hc[N], sc;

   pwm_fade_array #(
      .N_CH(N), .CNT_W(CW), .CLK_FREQ(CF), .PWM_FREQ(PF),
      .STEP_TICKS(ST), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .STEP(STP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
      .static_duty(static_duty), .leds(leds), .pwm_sync(pwm_sync)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int init_duty(input int i);
      return DMIN + i * ((DMAX - DMIN) / N);
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_tick = 0; m_phase = 0; m_pmode = 0; m_sync = 0; m_leds = 0;
      for (int i = 0; i < N; i++) begin
         m_duty[i] = init_duty(i);
         m_act[i]  = init_duty(i);
         m_dir[i]  = 0;
      end
   endtask

   // One clock of the reference behaviour, using the inputs seen at the edge.
   task automatic model_step();
      bit en, tk, entry;
      int md, sd;
      en = enable; md = int'(mode); sd = int'(static_duty);
      m_leds = 0;
      for (int i = 0; i < N; i++)
         if (en && md != 0 && m_cnt < m_act[i]) m_leds += (1 << i);
      m_sync = (en && m_cnt == 0) ? 1 : 0;
      if (!en) return;
      tk    = (m_tick == ST - 1);
      entry = (md == 2 && m_pmode != 2);
      if (m_cnt == PER - 1)
         for (int i = 0; i < N; i++) m_act[i] = m_duty[i];
      if (tk && md == 3) m_phase = 1 - m_phase;
      for (int i = 0; i < N; i++) begin
         if (entry) begin
            m_duty[i] = init_duty(i);
            m_dir[i]  = 0;
         end else if (md == 1) begin
            m_duty[i] = (sd > PER) ? PER : sd;
         end else if (md == 3 && tk) begin
            m_duty[i] = (((i % 2) == 0) == (m_phase == 1)) ? DMIN : DMAX;
         end else if (md == 2 && tk) begin
            if (m_dir[i] == 0) begin
               if (m_duty[i] + STP >= DMAX) begin m_duty[i] = DMAX; m_dir[i] = 1; end
               else m_duty[i] += STP;
            end else begin
               if (m_duty[i] <= DMIN + STP) begin m_duty[i] = DMIN; m_dir[i] = 0; end
               else m_duty[i] -= STP;
            end
         end
      end
      m_pmode = md;
      m_cnt   = (m_cnt + 1) % PER;
      m_tick  = (m_tick + 1) % ST;
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      chk("leds", int'(leds), m_leds);
      chk("pwm_sync", int'(pwm_sync), m_sync);
      for (int i = 0; i < N; i++) if (leds[i]) hc[i]++;
      if (pwm_sync) sc++;
   endtask

   task automatic win(input int n);
      for (int i = 0; i < N; i++) hc[i] = 0;
      sc = 0;
      repeat (n) cyc();
   endtask

   task automatic align_period();
      for (int k = 0; k < 2 * PER && m_cnt != 0; k++) cyc();
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; mode = 2'd0; static_duty = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_leds", int'(leds), 0);
      chk("rst_sync", int'(pwm_sync), 0);
      rst_n = 1'b1;

      // Breathe from reset stagger; third period still uses pre-tick duty.
      enable = 1'b1; mode = 2'd2;
      win(30);
      chk("sync_cnt30", sc, 3);
      for (int i = 0; i < N; i++) chk($sformatf("brth0_led%0d", i), hc[i], 3 * (i + 1));
      win(10);
      for (int i = 0; i < N; i++) chk($sformatf("brth1_led%0d", i), hc[i], i + 3);
      repeat (120) cyc();

      // Static duty, then an over-range value mid-period.
      mode = 2'd1; static_duty = 16'd3;
      align_period();
      repeat (PER) cyc();
      win(PER);
      for (int i = 0; i < N; i++) chk($sformatf("stat3_led%0d", i), hc[i], 3);
      repeat (5) cyc();
      static_duty = 16'd12;
      win(5);
      for (int i = 0; i < N; i++) chk($sformatf("stat_mid_led%0d", i), hc[i], (i < N) ? 0 : 0);
      win(PER);
      for (int i = 0; i < N; i++) chk($sformatf("stat12_led%0d", i), hc[i], PER);

      // Blink for a few ticks, model-checked every cycle.
      mode = 2'd3;
      repeat (90) cyc();

      // Pause with enable low at cnt 4.
      mode = 2'd2;
      repeat (30) cyc();
      for (int k = 0; k < 2 * PER && m_cnt != 4; k++) cyc();
      enable = 1'b0;
      win(15);
      chk("dis_hi", hc[0] + hc[1] + hc[2] + hc[3], 0);
      chk("dis_sync", sc, 0);
      enable = 1'b1;
      repeat (40) cyc();

      // Asynchronous reset between edges.
      #2 rst_n = 1'b0;
      #1;
      chk("arst_leds", int'(leds), 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      mode = 2'd2; enable = 1'b1;
      win(PER);
      for (int i = 0; i < N; i++) chk($sformatf("arst_led%0d", i), hc[i], i + 1);

      // Random segments of mode, enable and static duty.
      for (int s = 0; s < 60; s++) begin
         enable      = ($urandom_range(0, 5) != 0);
         mode        = 2'($urandom_range(0, 3));
         static_duty = CW'($urandom_range(0, 14));
         repeat ($urandom_range(1, 40)) cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
